// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like memory port between the fetch (inst)
// and load/store (data) requesters. At most one transaction is outstanding.
// A grant in IDLE moves to ADDR, where the owner's request is forwarded
// combinationally. Address acceptance moves to DATA, and the response
// returns to IDLE. Ties are broken round-robin against the last grant.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Owner / last_grant encoding: 0 = inst, 1 = data.
    state_t r_state;
    state_t w_state_next;
    logic   r_owner;
    logic   w_owner_next;
    logic   r_last_grant;
    logic   w_last_grant_next;

    // The owner's request line, used for both forwarding and abandon detection.
    logic   w_own_req;
    assign w_own_req = r_owner ? data_req : inst_req;

    // State, owner and round-robin history; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // Next-state logic: grant in IDLE, wait for address accept or abandon, wait for response.
    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_grant_next = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (inst_req || data_req) begin
                    // Tie goes to the side that did not win last time.
                    if (inst_req && data_req) begin
                        w_owner_next = ~r_last_grant;
                    end else begin
                        w_owner_next = data_req;
                    end
                    w_last_grant_next = w_owner_next;
                    w_state_next      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!w_own_req) begin
                    // Owner withdrew before acceptance: give the port up.
                    w_state_next = ST_IDLE;
                end else if (mem_addr_ok) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (mem_data_ok) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Phase qualifiers, forced low while reset is asserted so nothing leaks out.
    logic w_in_addr;
    logic w_in_data;
    logic w_accept;
    logic w_done;
    assign w_in_addr = resetn && (r_state == ST_ADDR);
    assign w_in_data = resetn && (r_state == ST_DATA);
    assign w_accept  = w_in_addr && w_own_req && mem_addr_ok;
    assign w_done    = w_in_data && mem_data_ok;

    // Output logic: forward owner fields in ADDR, steer handshakes to the owner only.
    always_comb begin
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = 2'd0;
        mem_wstrb    = 4'd0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (w_in_addr) begin
            mem_req = w_own_req;
            if (r_owner) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_wstrb = inst_wstrb;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end
        inst_addr_ok = w_accept && !r_owner;
        data_addr_ok = w_accept &&  r_owner;
        inst_data_ok = w_done   && !r_owner;
        data_data_ok = w_done   &&  r_owner;
    end

    // Read data is shared; each side qualifies it with its own data_ok.
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL use clock clk and reset resetn, where reset is synchronous and active-low.
REQ-002 Port clk  input  1  system clock; all state updates on posedge.
REQ-003 Port resetn  input  1  synchronous active-low reset.
REQ-004 Ports inst_req, inst_wr  input  1 each  fetch-side request / write flag.
REQ-005 Ports inst_size  input  2; inst_wstrb  input  4; inst_addr, inst_wdata  input  32  fetch-side request fields.
REQ-006 Ports inst_addr_ok, inst_data_ok  output  1 each; inst_rdata  output  32  fetch-side responses.
REQ-007 Ports data_req, data_wr  input  1 each; data_size  input  2; data_wstrb  input  4; data_addr, data_wdata  input  32  load/store-side request.
REQ-008 Ports data_addr_ok, data_data_ok  output  1 each; data_rdata  output  32  load/store-side responses.
REQ-009 Ports mem_req, mem_wr  output  1; mem_size  output  2; mem_wstrb  output  4; mem_addr, mem_wdata  output  32  shared-port request.
REQ-010 Ports mem_addr_ok, mem_data_ok  input  1; mem_rdata  input  32  shared-port responses.

Function
REQ-011 The block SHALL share one SRAM-like port between the fetch (inst) and load/store (data) requesters, with at most one outstanding transaction.
REQ-012 The FSM SHALL have states IDLE, ADDR, DATA plus a 1-bit owner register (0=inst, 1=data) and a 1-bit last_grant register.
REQ-013 In IDLE, if only one requester has req=1, the FSM SHALL grant it: owner<=that requester, go to ADDR next cycle.
REQ-014 In IDLE with both requesting, the FSM SHALL grant the requester opposite last_grant (round-robin); last_grant<=owner on every grant.
REQ-015 In IDLE, mem_req SHALL be 0 and no addr_ok/data_ok SHALL be returned to either requester.
REQ-016 In ADDR, mem_req SHALL equal owner's req, and mem_wr/size/wstrb/addr/wdata SHALL be owner's fields combinationally.
REQ-017 In ADDR, when mem_req=1 and mem_addr_ok=1, the FSM SHALL pulse owner's addr_ok that cycle and go to DATA.
REQ-018 In ADDR, if owner's req is 0 (protocol abandon), the FSM SHALL return to IDLE without issuing addr_ok.
REQ-019 In DATA, mem_req SHALL be 0; on mem_data_ok=1 the block SHALL pulse owner's data_ok the same cycle, pass mem_rdata to owner's rdata, and go to IDLE.
REQ-020 Minimum transaction latency SHALL be: req at cycle N -> mem_req at N+1 -> earliest data_ok at N+2; back-to-back grants SHALL be spaced at least 3 cycles.
REQ-021 The non-owner SHALL see addr_ok=0 and data_ok=0 at all times; mem_data_ok outside DATA SHALL be ignored.
REQ-022 inst_rdata and data_rdata SHALL both be wired to mem_rdata (qualified only by the respective data_ok).
REQ-023 In IDLE/DATA, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata SHALL be 0.

Reset
REQ-024 With resetn=0 at a posedge, state<=IDLE, owner<=0, last_grant<=0 (inst), so the first tie grants data.
REQ-025 During and after reset, mem_req, all addr_ok and all data_ok SHALL be 0; reset in ADDR or DATA SHALL abandon the transaction, and a subsequent mem_data_ok SHALL be ignored.

Verification
REQ-026 Single fetch: inst_req=1, addr=0x1C000000, mem_addr_ok=1 immediately, mem_data_ok next cycle with rdata=0x02800C0C -> mem_addr=0x1C000000 at N+1, inst_addr_ok at N+1, inst_data_ok with inst_rdata=0x02800C0C at N+2.
REQ-027 Tie after reset: inst_req=data_req=1 continuously -> grant order data, inst, data, inst; each grant only after prior data_ok.
REQ-028 Store pass-through: data_req=1, wr=1, wstrb=0xF, addr=0x00000100, wdata=0xDEADBEEF, mem_addr_ok delayed 3 cycles -> mem fields stable for all 3 cycles, data_addr_ok only in the accept cycle, inst_* outputs 0.
REQ-029 Stray response: mem_data_ok=1 in IDLE and in ADDR -> no data_ok to either side, state unchanged.
REQ-030 Reset mid-op: resetn=0 in DATA, then mem_data_ok=1 one cycle after release -> no data_ok pulses, state IDLE, next tie grants data.
REQ-031 Abandon: inst granted, inst_req dropped in ADDR before mem_addr_ok -> return to IDLE, no inst_addr_ok, pending data_req granted next.
